rn52_cmd_model: RTL and testbench
=================================

Name: rn52_cmd_model

Overview:
- Parametrised behavioural model of the RN52 command-mode interface, one generation beyond the fixed single-ACK model.
- Buffers a full command line from an external UART and decodes it on CR. Selects one of four 5-byte responses and streams it back byte by byte.
- Tracks song index, play state and volume for the I2S tone source.
- Sits in the testbench between the UART's RX/TX handshakes and the I2S monarch's song select.

Parameters:
- NUM_SONGS, 4: song count; song index wraps modulo NUM_SONGS (>=2).
- MAX_CMD_LEN, 8: line-buffer depth in bytes, excluding CR.
- VOL_MAX, 15: maximum volume; volume saturates in 0..VOL_MAX.
- VOL_RST, 8: volume after reset.
- RESP_DLY, 16: clk cycles from accepted CR to the first trmt of the response (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cmd_n  in  1  low = command mode requested
- rx_rdy  in  1  UART byte available
- rx_data  in  8  UART received byte
- clr_rx_rdy  out  1  one-cycle pulse, same cycle rx_rdy is consumed
- trmt  out  1  one-cycle start-transmit pulse
- tx_data  out  8  byte to transmit; stable from trmt until tx_done
- tx_done  in  1  UART finished the current byte
- song  out  $clog2(NUM_SONGS)  current song index
- playing  out  1  play/pause state
- volume  out  $clog2(VOL_MAX+1)  current volume
- busy  out  1  response pending or in flight

Behaviour:
- Reset values: song=0, playing=1, volume=VOL_RST, trmt=0, clr_rx_rdy=0, busy=0, tx_data=0, state=IDLE, line buffer empty, overflow=0, pending_cr=0.
- Response ROM: 20 bytes, four 5-byte strings: CMD="CMD\r\n" at 0, AOK="AOK\r\n" at 5, ERR="ERR\r\n" at 10, END="END\r\n" at 15.
- RX path is active in every state except IDLE.
  - clr_rx_rdy = rx_rdy.
  - 0x0A is discarded.
  - 0x0D sets pending_cr.
  - Any other byte is appended to the buffer if len<MAX_CMD_LEN; otherwise it sets overflow and is dropped.
- States:
  - IDLE: rx ignored (clr_rx_rdy still pulses). cmd_n=0 -> load CMD, go to DELAY.
  - LISTEN: pending_cr -> decode, apply the side effect, load AOK or ERR, clear buffer, overflow and pending_cr, go to DELAY. Else cmd_n=1 -> load END, go to DELAY.
  - DELAY: count RESP_DLY cycles -> SEND.
  - SEND: trmt=1 for one cycle with tx_data = ROM[addr] -> WAIT.
  - WAIT: on tx_done, if this was the 5th byte go to DONE; else addr++ and go to SEND. Each next trmt comes exactly 1 cycle after tx_done.
  - DONE: if the sent string was END -> IDLE. Else if cmd_n=1 -> load END, go to DELAY. Else -> LISTEN.
- Decode (exact match on the buffer; overflow forces ERR):
  - "AT+": song+1 mod NUM_SONGS, AOK.
  - "AT-": song-1 mod NUM_SONGS (0 -> NUM_SONGS-1), AOK.
  - "AP": toggle playing, AOK.
  - "AV+": volume+1, saturating at VOL_MAX, still AOK.
  - "AV-": volume-1, saturating at 0, still AOK.
  - Empty line or anything else: ERR, no side effect.
- Side effects are applied in the single decode cycle, before the response is sent.
- Bytes, including CR, arriving during DELAY/SEND/WAIT are still buffered. The pending_cr line is dispatched on the return to LISTEN.
  - A second CR while pending_cr=1 is dropped.
  - Bytes after a pending CR belong to the same buffer; no second line buffer.
- cmd_n rising mid-response: the current response completes, then END is sent.
- cmd_n re-falling before END completes has no effect until IDLE; then CMD is sent again.
- busy=1 in DELAY, SEND, WAIT and DONE.
- Async rst mid-response aborts immediately: trmt=0 and all state returns to reset values.

Decomposition:
- Package rn52_pkg:
  - state_t enum: IDLE, LISTEN, DELAY, SEND, WAIT, DONE.
  - resp_t enum: CMD, AOK, ERR, END, plus base-address constants.
  - Byte constants: CR=8'h0D, LF=8'h0A, '+'=8'h2B, '-'=8'h2D.
  - The 20-byte response ROM content as a localparam array.
- One sub-module: rn52_line_buf (parametrised MAX_CMD_LEN).
  - Inputs: push, byte, clr.
  - Outputs: buffer contents, len, overflow.

Test Plan:
- Reset, then cmd_n 1->0: TX bytes 43 4D 44 0D 0A. First trmt occurs RESP_DLY cycles after the FSM leaves IDLE. busy drops after the 5th tx_done.
- "AT+\r" x5 with NUM_SONGS=4: song goes 1,2,3,0,1, each reply 41 4F 4B 0D 0A. Then "AT-\r" from 0 gives song=3.
- "AV+\r" x10 from VOL_RST=8: volume saturates at 15, all replies AOK. "AP\r": playing goes 1->0.
- "XYZ\r" gives ERR (45 52 52 0D 0A) with song, volume and playing unchanged. Then 9 chars + CR with MAX_CMD_LEN=8 gives ERR and overflow clears afterwards.
- "AT+\r" sent while the prior AOK is still transmitting: second AOK starts after the first completes and song advances twice. cmd_n->1 during that AOK: AOK completes, then END 45 4E 44 0D 0A, then IDLE.
- rst asserted between bytes 2 and 3 of AOK: no further trmt, all outputs at reset values next cycle. cmd_n=0 after release gives a fresh CMD.

Source files
------------

// File: rtl/rn52_cmd_model_pkg.sv
// Shared types and constants for the RN52 command-mode model: FSM and
// response encodings, protocol byte values and the response string ROM.
package rn52_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LISTEN,
        DELAY,
        SEND,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CMD,
        AOK,
        ERR,
        END
    } resp_t;

    // Each response is a 5-byte string; these are their ROM start addresses
    localparam int unsigned RESP_LEN = 5;
    localparam logic [4:0] BASE_CMD = 5'd0;
    localparam logic [4:0] BASE_AOK = 5'd5;
    localparam logic [4:0] BASE_ERR = 5'd10;
    localparam logic [4:0] BASE_END = 5'd15;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] PLUS  = 8'h2B;
    localparam logic [7:0] MINUS = 8'h2D;
    localparam logic [7:0] CH_A  = 8'h41;
    localparam logic [7:0] CH_P  = 8'h50;
    localparam logic [7:0] CH_T  = 8'h54;
    localparam logic [7:0] CH_V  = 8'h56;

    localparam logic [7:0] RESP_ROM [20] = '{
        8'h43, 8'h4D, 8'h44, 8'h0D, 8'h0A,   // CMD\r\n
        8'h41, 8'h4F, 8'h4B, 8'h0D, 8'h0A,   // AOK\r\n
        8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A,   // ERR\r\n
        8'h45, 8'h4E, 8'h44, 8'h0D, 8'h0A    // END\r\n
    };

    function automatic logic [4:0] resp_base(input resp_t r);
        case (r)
            CMD:     return BASE_CMD;
            AOK:     return BASE_AOK;
            ERR:     return BASE_ERR;
            default: return BASE_END;
        endcase
    endfunction

    function automatic logic [4:0] rom_addr(input resp_t r, input logic [2:0] idx);
        return resp_base(r) + 5'(idx);
    endfunction

endpackage

// File: rtl/rn52_cmd_model_if.sv
// UART handshake and song/volume status bundle between the RN52 model
// (slave) and the surrounding testbench logic (master).
interface rn52_cmd_model_if #(
    parameter int NUM_SONGS = 4,
    parameter int VOL_MAX   = 15
);
    logic                             cmd_n;
    logic                             rx_rdy;
    logic [7:0]                       rx_data;
    logic                             clr_rx_rdy;
    logic                             trmt;
    logic [7:0]                       tx_data;
    logic                             tx_done;
    logic [$clog2(NUM_SONGS)-1:0]     song;
    logic                             playing;
    logic [$clog2(VOL_MAX+1)-1:0]     volume;
    logic                             busy;

    modport slave (
        input  cmd_n, rx_rdy, rx_data, tx_done,
        output clr_rx_rdy, trmt, tx_data, song, playing, volume, busy
    );

    modport master (
        output cmd_n, rx_rdy, rx_data, tx_done,
        input  clr_rx_rdy, trmt, tx_data, song, playing, volume, busy
    );
endinterface

// File: rtl/rn52_cmd_model_line_buf.sv
// Command line buffer. Slots beyond len are always zero, so a whole-buffer
// compare against a zero-padded pattern is an exact match.
module rn52_line_buf #(
    parameter int MAX_CMD_LEN = 8,
    localparam int LEN_W = $clog2(MAX_CMD_LEN+1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [7:0]                    din,
    input  logic                          clr,
    output logic [MAX_CMD_LEN-1:0][7:0]   data,
    output logic [LEN_W-1:0]              len,
    output logic                          overflow
);

    // Append bytes in order; a clear empties the buffer but keeps a byte
    // arriving in the same cycle as the first byte of the next line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data     <= '0;
            len      <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            data     <= '0;
            overflow <= 1'b0;
            len      <= push ? LEN_W'(1) : '0;
            if (push)
                data[0] <= din;
        end else if (push) begin
            if (len < LEN_W'(MAX_CMD_LEN)) begin
                for (int i = 0; i < MAX_CMD_LEN; i++)
                    if (len == LEN_W'(i))
                        data[i] <= din;
                len <= len + 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rn52_cmd_model.sv
// RN52 command-mode model: buffers UART command lines, decodes them on CR,
// updates song/play/volume and streams a 5-byte reply after a fixed delay.
module rn52_cmd_model
    import rn52_pkg::*;
#(
    parameter int NUM_SONGS   = 4,
    parameter int MAX_CMD_LEN = 8,
    parameter int VOL_MAX     = 15,
    parameter int VOL_RST     = 8,
    parameter int RESP_DLY    = 16
) (
    input  logic                clk,
    input  logic                rst,
    rn52_cmd_model_if.slave     bus
);

    localparam int SONG_W = $clog2(NUM_SONGS);
    localparam int VOL_W  = $clog2(VOL_MAX+1);
    localparam int LEN_W  = $clog2(MAX_CMD_LEN+1);
    localparam int DLY_W  = $clog2(RESP_DLY+1);

    typedef logic [MAX_CMD_LEN-1:0][7:0] line_t;

    function automatic line_t pat(input logic [7:0] c0, c1, c2);
        line_t p;
        p    = '0;
        p[0] = c0;
        p[1] = c1;
        p[2] = c2;
        return p;
    endfunction

    state_t              state_q, state_d;
    resp_t               resp_q, resp_d;
    logic [2:0]          idx_q, idx_d;
    logic [DLY_W-1:0]    dly_q, dly_d;
    logic [7:0]          tx_q, tx_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic                play_q, play_d;
    logic [VOL_W-1:0]    vol_q, vol_d;
    logic                pend_q;

    line_t               lb_data;
    logic [LEN_W-1:0]    lb_len;
    logic                lb_ovf;

    logic rx_v, cr_in, push, decode;
    logic hit_tp, hit_tm, hit_ap, hit_vp, hit_vm;

    assign rx_v   = (state_q != IDLE) && bus.rx_rdy;
    assign cr_in  = rx_v && (bus.rx_data == CR);
    assign push   = rx_v && (bus.rx_data != CR) && (bus.rx_data != LF);
    assign decode = (state_q == LISTEN) && pend_q;

    assign hit_tp = !lb_ovf && lb_len == LEN_W'(3) && lb_data == pat(CH_A, CH_T, PLUS);
    assign hit_tm = !lb_ovf && lb_len == LEN_W'(3) && lb_data == pat(CH_A, CH_T, MINUS);
    assign hit_ap = !lb_ovf && lb_len == LEN_W'(2) && lb_data == pat(CH_A, CH_P, 8'h00);
    assign hit_vp = !lb_ovf && lb_len == LEN_W'(3) && lb_data == pat(CH_A, CH_V, PLUS);
    assign hit_vm = !lb_ovf && lb_len == LEN_W'(3) && lb_data == pat(CH_A, CH_V, MINUS);

    rn52_line_buf #(.MAX_CMD_LEN(MAX_CMD_LEN)) u_line_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .din      (bus.rx_data),
        .clr      (decode),
        .data     (lb_data),
        .len      (lb_len),
        .overflow (lb_ovf)
    );

    // A CR only arms dispatch; a second CR while armed is absorbed
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pend_q <= 1'b0;
        else if (decode)
            pend_q <= cr_in;
        else if (cr_in)
            pend_q <= 1'b1;
    end

    // State and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            resp_q  <= CMD;
            idx_q   <= '0;
            dly_q   <= '0;
            tx_q    <= '0;
            song_q  <= '0;
            play_q  <= 1'b1;
            vol_q   <= VOL_W'(VOL_RST);
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
            tx_q    <= tx_d;
            song_q  <= song_d;
            play_q  <= play_d;
            vol_q   <= vol_d;
        end
    end

    // Next-state, reply selection and decode side effects
    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        tx_d    = tx_q;
        song_d  = song_q;
        play_d  = play_q;
        vol_d   = vol_q;
        case (state_q)
            IDLE: begin
                if (!bus.cmd_n) begin
                    resp_d  = CMD;
                    state_d = DELAY;
                    idx_d   = '0;
                    dly_d   = '0;
                end
            end
            LISTEN: begin
                if (pend_q) begin
                    if (hit_tp)
                        song_d = (song_q == SONG_W'(NUM_SONGS-1)) ? '0 : song_q + 1'b1;
                    if (hit_tm)
                        song_d = (song_q == '0) ? SONG_W'(NUM_SONGS-1) : song_q - 1'b1;
                    if (hit_ap)
                        play_d = ~play_q;
                    if (hit_vp && vol_q != VOL_W'(VOL_MAX))
                        vol_d = vol_q + 1'b1;
                    if (hit_vm && vol_q != '0)
                        vol_d = vol_q - 1'b1;
                    resp_d  = (hit_tp || hit_tm || hit_ap || hit_vp || hit_vm) ? AOK : ERR;
                    state_d = DELAY;
                    idx_d   = '0;
                    dly_d   = '0;
                end else if (bus.cmd_n) begin
                    resp_d  = END;
                    state_d = DELAY;
                    idx_d   = '0;
                    dly_d   = '0;
                end
            end
            DELAY: begin
                if (dly_q == DLY_W'(RESP_DLY-1)) begin
                    state_d = SEND;
                    tx_d    = RESP_ROM[rom_addr(resp_q, idx_q)];
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            SEND: state_d = WAIT;
            WAIT: begin
                if (bus.tx_done) begin
                    if (idx_q == 3'(RESP_LEN-1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_d    = RESP_ROM[rom_addr(resp_q, idx_q + 3'd1)];
                        state_d = SEND;
                    end
                end
            end
            DONE: begin
                if (resp_q == END) begin
                    state_d = IDLE;
                end else if (bus.cmd_n) begin
                    resp_d  = END;
                    state_d = DELAY;
                    idx_d   = '0;
                    dly_d   = '0;
                end else begin
                    state_d = LISTEN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.clr_rx_rdy = bus.rx_rdy & ~rst;
    assign bus.trmt       = (state_q == SEND);
    assign bus.tx_data    = tx_q;
    assign bus.song       = song_q;
    assign bus.playing    = play_q;
    assign bus.volume     = vol_q;
    assign bus.busy       = (state_q == DELAY) || (state_q == SEND) ||
                            (state_q == WAIT)  || (state_q == DONE);

endmodule

// File: tb/tb_rn52_cmd_model.sv
// Self-checking bench for rn52_cmd_model: directed table, random commands
// against a string-level reference model, and multi-cycle corner sequences.
module tb_rn52_cmd_model;

    localparam int NUM_SONGS   = 4;
    localparam int MAX_CMD_LEN = 8;
    localparam int VOL_MAX     = 15;
    localparam int VOL_RST     = 8;
    localparam int RESP_DLY    = 16;

    localparam logic [39:0] R_CMD = 40'h434D440D0A;
    localparam logic [39:0] R_AOK = 40'h414F4B0D0A;
    localparam logic [39:0] R_ERR = 40'h4552520D0A;
    localparam logic [39:0] R_END = 40'h454E440D0A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rn52_cmd_model_if #(.NUM_SONGS(NUM_SONGS), .VOL_MAX(VOL_MAX)) bus ();

    rn52_cmd_model #(
        .NUM_SONGS(NUM_SONGS), .MAX_CMD_LEN(MAX_CMD_LEN), .VOL_MAX(VOL_MAX),
        .VOL_RST(VOL_RST), .RESP_DLY(RESP_DLY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int tx_gap   = 3;
    logic [7:0] cap_q[$];

    typedef struct {
        string       line;
        logic [39:0] resp;
        int          song;
        int          playing;
        int          volume;
    } vec_t;
    vec_t tab[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART transmitter stand-in: capture each trmt byte, answer tx_done later
    initial begin
        int gap_cnt;
        gap_cnt = 0;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.tx_done = 1'b0;
                gap_cnt = 0;
            end else begin
                if (bus.tx_done) bus.tx_done = 1'b0;
                if (bus.trmt) begin
                    cap_q.push_back(bus.tx_data);
                    gap_cnt = tx_gap;
                end else if (gap_cnt > 0) begin
                    gap_cnt--;
                    if (gap_cnt == 0) bus.tx_done = 1'b1;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        #1;
        chk("clr_rx_rdy", bus.clr_rx_rdy, 1'b1);
        @(negedge clk);
        bus.rx_rdy  = 1'b0;
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        send_byte(8'h0D);
    endtask

    task automatic wait_cap(input int n);
        for (int i = 0; i < 3000 && cap_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic get_resp(input string name, input logic [39:0] exp);
        logic [39:0] r;
        r = '0;
        wait_cap(5);
        if (cap_q.size() < 5) begin
            chk({name, "_timeout"}, 64'(cap_q.size()), 64'd5);
        end else begin
            for (int i = 0; i < 5; i++) r = {r[31:0], cap_q.pop_front()};
            chk(name, r, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("busy_low", bus.busy, 1'b0);
    endtask

    task automatic add(input string l, input logic [39:0] r, input int s, p, v);
        vec_t e;
        e.line = l; e.resp = r; e.song = s; e.playing = p; e.volume = v;
        tab.push_back(e);
    endtask

    initial begin
        int t_busy, t_trmt;
        int m_song, m_play, m_vol, sel;
        string line;
        logic [39:0] exp_r;

        bus.cmd_n = 1'b1; bus.rx_rdy = 1'b0; bus.rx_data = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values (checked with reset held and just after release)
        chk("rst_song", bus.song, 0);
        chk("rst_playing", bus.playing, 1);
        chk("rst_volume", bus.volume, VOL_RST);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_trmt", bus.trmt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_clr_rx_rdy", bus.clr_rx_rdy, 0);

        // Entering command mode: latency from leaving IDLE to first trmt
        bus.cmd_n = 1'b0;
        t_busy = -1; t_trmt = -1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (bus.busy && t_busy < 0) t_busy = t;
            if (bus.trmt) begin t_trmt = t; break; end
        end
        chk("cmd_first_trmt_latency", 64'(t_trmt - t_busy), 64'(RESP_DLY));
        get_resp("cmd_resp", R_CMD);
        wait_idle();

        // Directed table
        add("AT+", R_AOK, 1, 1, 8);  add("AT+", R_AOK, 2, 1, 8);
        add("AT+", R_AOK, 3, 1, 8);  add("AT+", R_AOK, 0, 1, 8);
        add("AT+", R_AOK, 1, 1, 8);  add("AT-", R_AOK, 0, 1, 8);
        add("AT-", R_AOK, 3, 1, 8);
        for (int v = 9; v <= 18; v++) add("AV+", R_AOK, 3, 1, (v > VOL_MAX) ? VOL_MAX : v);
        add("AP", R_AOK, 3, 0, 15);
        add("XYZ", R_ERR, 3, 0, 15);
        add("ABCDEFGHI", R_ERR, 3, 0, 15);
        add("AV-", R_AOK, 3, 0, 14);
        add("", R_ERR, 3, 0, 14);
        foreach (tab[i]) begin
            send_line(tab[i].line);
            get_resp($sformatf("tab%0d_resp", i), tab[i].resp);
            wait_idle();
            chk($sformatf("tab%0d_song", i), bus.song, tab[i].song);
            chk($sformatf("tab%0d_playing", i), bus.playing, tab[i].playing);
            chk($sformatf("tab%0d_volume", i), bus.volume, tab[i].volume);
        end

        // Random commands against a string-level reference model
        m_song = 3; m_play = 0; m_vol = 14;
        for (int k = 0; k < 40; k++) begin
            tx_gap = $urandom_range(1, 4);
            sel = $urandom_range(0, 7);
            case (sel)
                0: line = "AT+";
                1: line = "AT-";
                2: line = "AP";
                3: line = "AV+";
                4: line = "AV-";
                5: begin
                    line = "";
                    for (int j = 0; j < 9 + $urandom_range(0, 3); j++) line = {line, "AV+"};
                end
                6: line = "";
                default: begin
                    case ($urandom_range(0, 4))
                        0: line = "AT";
                        1: line = "at+";
                        2: line = "AP+";
                        3: line = "AV";
                        default: line = "Q";
                    endcase
                end
            endcase
            exp_r = R_AOK;
            if (line.len() > MAX_CMD_LEN)  exp_r = R_ERR;
            else if (line == "AT+")        m_song = (m_song + 1) % NUM_SONGS;
            else if (line == "AT-")        m_song = (m_song + NUM_SONGS - 1) % NUM_SONGS;
            else if (line == "AP")         m_play = 1 - m_play;
            else if (line == "AV+")        m_vol = (m_vol < VOL_MAX) ? m_vol + 1 : VOL_MAX;
            else if (line == "AV-")        m_vol = (m_vol > 0) ? m_vol - 1 : 0;
            else                           exp_r = R_ERR;
            send_line(line);
            get_resp($sformatf("rnd%0d_resp", k), exp_r);
            wait_idle();
            chk($sformatf("rnd%0d_song", k), bus.song, m_song);
            chk($sformatf("rnd%0d_playing", k), bus.playing, m_play);
            chk($sformatf("rnd%0d_volume", k), bus.volume, m_vol);
        end
        tx_gap = 3;

        // Second line arrives mid-reply; cmd_n rises during the second reply
        send_line("AT+");
        wait_cap(1);
        send_line("AT+");
        wait_cap(6);
        bus.cmd_n = 1'b1;
        get_resp("pipe_resp1", R_AOK);
        get_resp("pipe_resp2", R_AOK);
        get_resp("pipe_end", R_END);
        wait_idle();
        chk("pipe_song", bus.song, (m_song + 2) % NUM_SONGS);
        repeat (40) @(negedge clk);
        chk("pipe_idle_quiet", 64'(cap_q.size()), 0);
        chk("pipe_idle_busy", bus.busy, 0);

        // Re-enter command mode, then reset between bytes 2 and 3 of an AOK
        bus.cmd_n = 1'b0;
        get_resp("cmd2_resp", R_CMD);
        wait_idle();
        send_line("AT+");
        wait_cap(2);
        rst = 1'b1;
        #1;
        chk("abort_trmt", bus.trmt, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_song", bus.song, 0);
        chk("abort_playing", bus.playing, 1);
        chk("abort_volume", bus.volume, VOL_RST);
        chk("abort_tx_data", bus.tx_data, 0);
        bus.cmd_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cap_q.delete();
        repeat (40) @(negedge clk);
        chk("abort_no_trmt", 64'(cap_q.size()), 0);
        bus.cmd_n = 1'b0;
        get_resp("cmd3_resp", R_CMD);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
